// File: rtl/my_regfile_wctl_if.sv
// Write-side bus of the 16x16 register file: two requesters
// and the single write port, grouped for the write controller.
interface my_regfile_wctl_if #(
   parameter int AW    = 4,
   parameter int WIDTH = 16
);
   logic             req_a;
   logic [AW-1:0]    addr_a;
   logic [WIDTH-1:0] data_a;
   logic             gnt_a;
   logic             req_b;
   logic [AW-1:0]    addr_b;
   logic [WIDTH-1:0] data_b;
   logic             gnt_b;
   logic             we;
   logic [AW-1:0]    wn;
   logic [WIDTH-1:0] wd;

   modport slave (
      input  req_a, addr_a, data_a,
      input  req_b, addr_b, data_b,
      output gnt_a, gnt_b,
      output we, wn, wd
   );

   modport master (
      output req_a, addr_a, data_a,
      output req_b, addr_b, data_b,
      input  gnt_a, gnt_b,
      input  we, wn, wd
   );
endinterface

// File: rtl/my_regfile_wctl.sv
// Register file write-port controller: loads rf[i]=i after reset,
// then round-robin arbitrates requesters A and B onto the port.
module my_regfile_wctl #(
   parameter int NREG  = 16,
   parameter int AW    = 4,
   parameter int WIDTH = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   my_regfile_wctl_if.slave    wr_if,
   output logic                init_busy_o,
   output logic [7:0]          conflicts_o
);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic             last_q, last_d;   // 1: B won last
   logic             we_q, we_d;
   logic [AW-1:0]    wn_q, wn_d;
   logic [WIDTH-1:0] wd_q, wd_d;
   logic             gnt_a_q, gnt_a_d;
   logic             gnt_b_q, gnt_b_d;
   logic             busy_q, busy_d;
   logic [7:0]       conf_q, conf_d;
   logic             elig_a, elig_b;
   logic             pick_a, pick_b;

   // next-state: init sweep, then round-robin grant selection
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      we_d    = 1'b0;
      wn_d    = wn_q;
      wd_d    = wd_q;
      gnt_a_d = 1'b0;
      gnt_b_d = 1'b0;
      busy_d  = 1'b0;
      conf_d  = conf_q;
      elig_a  = 1'b0;
      elig_b  = 1'b0;
      pick_a  = 1'b0;
      pick_b  = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            we_d   = 1'b1;
            wn_d   = cnt_q;
            wd_d   = WIDTH'(cnt_q);
            cnt_d  = cnt_q + 1'b1;
            busy_d = 1'b1;
            if (cnt_q == AW'(NREG - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // a req seen alongside its own grant is the old one
            elig_a = wr_if.req_a & ~gnt_a_q;
            elig_b = wr_if.req_b & ~gnt_b_q;
            pick_a = elig_a & (~elig_b | last_q);
            pick_b = elig_b & ~pick_a;
            if (elig_a && elig_b && conf_q != 8'hFF) begin
               conf_d = conf_q + 8'd1;
            end
            if (pick_a) begin
               gnt_a_d = 1'b1;
               we_d    = 1'b1;
               wn_d    = wr_if.addr_a;
               wd_d    = wr_if.data_a;
               last_d  = 1'b0;
            end
            if (pick_b) begin
               gnt_b_d = 1'b1;
               we_d    = 1'b1;
               wn_d    = wr_if.addr_b;
               wd_d    = wr_if.data_b;
               last_d  = 1'b1;
            end
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         wn_q    <= '0;
         wd_q    <= '0;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         busy_q  <= 1'b1;
         conf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         we_q    <= we_d;
         wn_q    <= wn_d;
         wd_q    <= wd_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         busy_q  <= busy_d;
         conf_q  <= conf_d;
      end
   end

   assign wr_if.we    = we_q;
   assign wr_if.wn    = wn_q;
   assign wr_if.wd    = wd_q;
   assign wr_if.gnt_a = gnt_a_q;
   assign wr_if.gnt_b = gnt_b_q;
   assign init_busy_o = busy_q;
   assign conflicts_o = conf_q;

endmodule

// File: tb/tb_my_regfile_wctl.sv
// Bench for my_regfile_wctl: random requesters against a
// cycle-level reference of init sweep and round-robin grants.
module tb_my_regfile_wctl;
   localparam int NREG  = 16;
   localparam int AW    = 4;
   localparam int WIDTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       init_busy;
   logic [7:0] conflicts;

   my_regfile_wctl_if #(.AW(AW), .WIDTH(WIDTH)) bus ();

   my_regfile_wctl #(
      .NREG(NREG), .AW(AW), .WIDTH(WIDTH)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .wr_if(bus),
      .init_busy_o(init_busy),
      .conflicts_o(conflicts)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // downstream register file fed by the DUT write port
   logic [WIDTH-1:0] rf_dut [NREG];
   always @(posedge clk) begin
      if (bus.we === 1'b1) rf_dut[bus.wn] <= bus.wd;
   end

   // reference: writes done since reset, who has priority next,
   // conflict tally, last presented address/data
   int m_done;
   bit m_afirst;
   int m_conf;
   bit m_ga, m_gb;
   int m_wn, m_wd;
   int rf_m [NREG];
   int p_req  [2];
   int p_keep [2];

   task automatic model_reset();
      m_done   = 0;
      m_afirst = 1'b1;
      m_conf   = 0;
      m_ga     = 1'b0;
      m_gb     = 1'b0;
      m_wn     = 0;
      m_wd     = 0;
   endtask

   task automatic new_a();
      bus.req_a  = 1'b1;
      bus.addr_a = AW'($urandom_range(NREG - 1));
      bus.data_a = WIDTH'($urandom);
   endtask

   task automatic new_b();
      bus.req_b  = 1'b1;
      bus.addr_b = AW'($urandom_range(NREG - 1));
      bus.data_b = WIDTH'($urandom);
   endtask

   task automatic step();
      bit ea, eb, ga, gb, we, busy;
      ga = 1'b0;
      gb = 1'b0;
      if (m_done < NREG) begin
         we   = 1'b1;
         busy = 1'b1;
         m_wn = m_done;
         m_wd = m_done;
         m_done++;
      end else begin
         busy = 1'b0;
         ea = bus.req_a && !m_ga;
         eb = bus.req_b && !m_gb;
         if (ea && eb) begin
            if (m_conf < 255) m_conf++;
            ga = m_afirst;
            gb = !m_afirst;
         end else begin
            ga = ea;
            gb = eb;
         end
         we = ga || gb;
         if (ga) begin
            m_wn = int'(bus.addr_a);
            m_wd = int'(bus.data_a);
            m_afirst = 1'b0;
         end
         if (gb) begin
            m_wn = int'(bus.addr_b);
            m_wd = int'(bus.data_b);
            m_afirst = 1'b1;
         end
      end
      if (we) rf_m[m_wn] = m_wd;
      m_ga = ga;
      m_gb = gb;
      @(posedge clk);
      #1;
      chk("gnt_a", 32'(bus.gnt_a), 32'(ga));
      chk("gnt_b", 32'(bus.gnt_b), 32'(gb));
      chk("we", 32'(bus.we), 32'(we));
      chk("wn", 32'(bus.wn), 32'(m_wn));
      chk("wd", 32'(bus.wd), 32'(m_wd));
      chk("init_busy", 32'(init_busy), 32'(busy));
      chk("conflicts", 32'(conflicts), 32'(m_conf));
      if (ga) begin
         if ($urandom_range(99) < p_keep[0]) new_a();
         else bus.req_a = 1'b0;
      end else if (!bus.req_a && $urandom_range(99) < p_req[0]) begin
         new_a();
      end
      if (gb) begin
         if ($urandom_range(99) < p_keep[1]) new_b();
         else bus.req_b = 1'b0;
      end else if (!bus.req_b && $urandom_range(99) < p_req[1]) begin
         new_b();
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      chk({tag, "_we"}, 32'(bus.we), 0);
      chk({tag, "_gnt"}, 32'({bus.gnt_a, bus.gnt_b}), 0);
      chk({tag, "_wn"}, 32'(bus.wn), 0);
      chk({tag, "_wd"}, 32'(bus.wd), 0);
      chk({tag, "_busy"}, 32'(init_busy), 1);
      chk({tag, "_conf"}, 32'(conflicts), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_pol(input int ra, input int ka,
                          input int rb, input int kb);
      p_req[0]  = ra;
      p_keep[0] = ka;
      p_req[1]  = rb;
      p_keep[1] = kb;
   endtask

   initial begin
      bus.req_a  = 1'b0;
      bus.addr_a = '0;
      bus.data_a = '0;
      bus.req_b  = 1'b0;
      bus.addr_b = '0;
      bus.data_b = '0;
      set_pol(0, 0, 0, 0);
      #3;
      do_reset("rst0");

      // init sweep with no traffic
      repeat (18) step();
      chk("rf9", 32'(rf_dut[9]), 9);

      // one uncontested write
      bus.req_a  = 1'b1;
      bus.addr_a = 4'd3;
      bus.data_a = 16'hBEEF;
      repeat (3) step();
      chk("rf3", 32'(rf_dut[3]), 32'h0000BEEF);

      // both requesters held high
      set_pol(0, 100, 0, 100);
      new_a();
      new_b();
      repeat (6) step();

      // B alone, held high; reset during a B grant
      set_pol(0, 0, 0, 100);
      repeat (6) step();
      for (int i = 0; i < 4 && !m_gb; i++) step();
      do_reset("rst_gnt");

      // requests held across init; A must win first
      set_pol(0, 100, 0, 100);
      new_a();
      new_b();
      repeat (16) step();
      step();
      chk("first_a", 32'(bus.gnt_a), 1);
      repeat (5) step();

      // reset in the middle of init
      set_pol(0, 0, 0, 0);
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      do_reset("rst_pre");
      repeat (7) step();
      chk("mid_wn", 32'(bus.wn), 6);
      do_reset("rst_mid");

      // random traffic
      for (int blk = 0; blk < 8; blk++) begin
         set_pol($urandom_range(100), $urandom_range(100),
                 $urandom_range(100), $urandom_range(100));
         repeat (50) step();
      end

      // drain and compare the whole register file
      set_pol(0, 0, 0, 0);
      repeat (8) step();
      for (int i = 0; i < NREG; i++) begin
         chk($sformatf("rf[%0d]", i), 32'(rf_dut[i]), 32'(rf_m[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
